// File: rtl/sseg_pkg.sv
// Shared types and constants for the six-digit message controller:
// FSM states, status codes and the fixed status messages with their digit masks.
package sseg_pkg;

    typedef enum logic {
        S_ENTRY = 1'b0,
        S_MSG   = 1'b1
    } state_t;

    localparam logic [1:0] STAT_GRANTED = 2'd0;
    localparam logic [1:0] STAT_DENIED  = 2'd1;
    localparam logic [1:0] STAT_LOCKED  = 2'd2;

    typedef struct packed {
        logic [23:0] hex;
        logic [5:0]  en;
    } msg_t;

    localparam msg_t MSG_GRANTED = {24'hACCE55, 6'b111111};
    localparam msg_t MSG_DENIED  = {24'hDEAD00, 6'b111100};
    localparam msg_t MSG_LOCKED  = {24'hC105ED, 6'b111111};

    // Code 3 is undefined upstream and is shown as a denial.
    function automatic msg_t msg_lookup(input logic [1:0] code);
        case (code)
            STAT_GRANTED: return MSG_GRANTED;
            STAT_LOCKED:  return MSG_LOCKED;
            default:      return MSG_DENIED;
        endcase
    endfunction

endpackage

// File: rtl/msg_timer.sv
// Message timer: saturating hold down-counter plus blink-phase generator.
// The phase output runs one cycle ahead so the controller can register it straight into dig_en.
module msg_timer #(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_run,
    output logic expire,
    output logic phase
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_CYCLES - 1);
    // Load state is the state one blink step past "lit, count BLINK-1".
    localparam logic [BW-1:0] BLINK_LOAD   = (BLINK_CYCLES > 1) ? BW'(BLINK_CYCLES - 2) : '0;
    localparam logic          PHASE_LOAD   = (BLINK_CYCLES > 1);

    logic [HW-1:0] r_hold;
    logic [BW-1:0] r_blink;
    logic          r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold  <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
        end else if (i_load) begin
            r_hold  <= HOLD_LOAD;
            r_blink <= BLINK_LOAD;
            r_phase <= PHASE_LOAD;
        end else if (i_run) begin
            if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end
            if (r_blink == '0) begin
                r_blink <= BLINK_RELOAD;
                r_phase <= ~r_phase;
            end else begin
                r_blink <= r_blink - 1'b1;
            end
        end
    end

    assign expire = (r_hold == '0);
    assign phase  = r_phase;

endmodule

// File: rtl/sseg_msg_ctrl.sv
// Six-digit HEX display arbiter: shows the keypad entry buffer (optionally masked)
// or a timed/blinking status message requested by the access-check logic.
module sseg_msg_ctrl
    import sseg_pkg::*;
#(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int MASK_ENTRY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        entry_valid,
    input  logic [3:0]  entry_digit,
    input  logic        entry_clr,
    input  logic        stat_req,
    input  logic [1:0]  stat_code,
    output logic        stat_ack,
    output logic        busy,
    output logic [23:0] hex_out,
    output logic [5:0]  dig_en
);

    state_t      r_state;
    logic [23:0] r_buf;
    logic [2:0]  r_cnt;
    logic [23:0] r_hex;
    logic [5:0]  r_dig_en;
    logic        r_ack;
    logic        r_busy;
    logic        r_locked;

    logic [23:0] w_buf_next;
    logic [2:0]  w_cnt_next;
    logic [23:0] w_view;
    logic [5:0]  w_en_view;
    logic        w_accept;
    logic        w_expire;
    logic        w_phase;
    msg_t        w_msg;

    assign w_accept = (r_state == S_ENTRY) && stat_req;
    assign w_msg    = msg_lookup(stat_code);

    msg_timer #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_run  (r_state == S_MSG),
        .expire (w_expire),
        .phase  (w_phase)
    );

    always_comb begin
        w_buf_next = r_buf;
        w_cnt_next = r_cnt;
        if (entry_clr) begin
            w_buf_next = '0;
            w_cnt_next = '0;
        end else if (entry_valid && (r_cnt < 3'd6)) begin
            w_buf_next = {r_buf[19:0], entry_digit};
            w_cnt_next = r_cnt + 3'd1;
        end
    end

    // Older digits read as 8 when masked; the newest (HEX0) is always shown as typed.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_view
            assign w_view[gi*4 +: 4] = ((MASK_ENTRY != 0) && (gi != 0) && (3'(gi) < w_cnt_next))
                                       ? 4'h8 : w_buf_next[gi*4 +: 4];
            assign w_en_view[gi]     = (3'(gi) < w_cnt_next);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_ENTRY;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_hex    <= '0;
            r_dig_en <= '0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_ENTRY: begin
                    if (stat_req) begin
                        r_state  <= S_MSG;
                        r_ack    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_buf    <= '0;
                        r_cnt    <= '0;
                        r_hex    <= w_msg.hex;
                        r_dig_en <= w_msg.en;
                        r_locked <= (stat_code == STAT_LOCKED);
                    end else begin
                        r_buf    <= w_buf_next;
                        r_cnt    <= w_cnt_next;
                        r_hex    <= w_view;
                        r_dig_en <= w_en_view;
                    end
                end
                S_MSG: begin
                    if ((r_locked && entry_clr) || (!r_locked && w_expire)) begin
                        r_state  <= S_ENTRY;
                        r_busy   <= 1'b0;
                        r_hex    <= '0;
                        r_dig_en <= '0;
                        r_locked <= 1'b0;
                    end else if (r_locked) begin
                        r_dig_en <= {6{w_phase}};
                    end
                end
                default: r_state <= S_ENTRY;
            endcase
        end
    end

    assign stat_ack = r_ack;
    assign busy     = r_busy;
    assign hex_out  = r_hex;
    assign dig_en   = r_dig_en;

endmodule

// File: tb/tb_sseg_msg_ctrl.sv
// Directed bench for sseg_msg_ctrl with short hold/blink periods and masked entry.
module tb_sseg_msg_ctrl;

    localparam int HOLD  = 20;
    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        entry_valid;
    logic [3:0]  entry_digit;
    logic        entry_clr;
    logic        stat_req;
    logic [1:0]  stat_code;
    logic        stat_ack;
    logic        busy;
    logic [23:0] hex_out;
    logic [5:0]  dig_en;

    int n_checks = 0;
    int n_fail   = 0;

    sseg_msg_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK),
        .MASK_ENTRY   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .entry_valid (entry_valid),
        .entry_digit (entry_digit),
        .entry_clr   (entry_clr),
        .stat_req    (stat_req),
        .stat_code   (stat_code),
        .stat_ack    (stat_ack),
        .busy        (busy),
        .hex_out     (hex_out),
        .dig_en      (dig_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++; if (hex_out !== 24'h0) begin n_fail++; $display("FAIL reset_hex: got %h want 000000", hex_out); end
        n_checks++; if (dig_en !== 6'h00) begin n_fail++; $display("FAIL reset_en: got %b want 000000", dig_en); end
        n_checks++; if (stat_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", stat_ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        $display("reset: hex=%h en=%b ack=%b busy=%b", hex_out, dig_en, stat_ack, busy);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_entry();
        logic [23:0] exp_hex [7] = '{24'h000001, 24'h000082, 24'h000883, 24'h008884,
                                     24'h088885, 24'h888886, 24'h888886};
        logic [5:0]  exp_en  [7] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, 6'h3F};
        for (int i = 0; i < 7; i++) begin
            entry_valid = 1'b1; entry_digit = 4'(i + 1);
            tick();
            entry_valid = 1'b0;
            $display("entry digit %0d: hex=%h en=%b", i + 1, hex_out, dig_en);
            n_checks++; if (hex_out !== exp_hex[i]) begin n_fail++; $display("FAIL entry_hex[%0d]: got %h want %h", i, hex_out, exp_hex[i]); end
            n_checks++; if (dig_en !== exp_en[i]) begin n_fail++; $display("FAIL entry_en[%0d]: got %b want %b", i, dig_en, exp_en[i]); end
        end
        entry_clr = 1'b1; entry_valid = 1'b1; entry_digit = 4'h9;
        tick();
        entry_clr = 1'b0; entry_valid = 1'b0;
        $display("entry clr+valid: hex=%h en=%b", hex_out, dig_en);
        n_checks++; if (hex_out !== 24'h0) begin n_fail++; $display("FAIL clr_hex: got %h want 000000", hex_out); end
        n_checks++; if (dig_en !== 6'h00) begin n_fail++; $display("FAIL clr_en: got %b want 000000", dig_en); end
    endtask

    task automatic test_granted();
        entry_valid = 1'b1; entry_digit = 4'h9;
        tick();
        n_checks++; if (hex_out !== 24'h000009) begin n_fail++; $display("FAIL pre_grant_hex: got %h want 000009", hex_out); end
        stat_req = 1'b1; stat_code = 2'd0; entry_digit = 4'h5;
        tick();
        stat_req = 1'b0; entry_valid = 1'b0;
        $display("granted: ack=%b busy=%b hex=%h en=%b", stat_ack, busy, hex_out, dig_en);
        n_checks++; if (stat_ack !== 1'b1) begin n_fail++; $display("FAIL grant_ack: got %b want 1", stat_ack); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL grant_busy: got %b want 1", busy); end
        n_checks++; if (hex_out !== 24'hACCE55) begin n_fail++; $display("FAIL grant_hex: got %h want acce55", hex_out); end
        n_checks++; if (dig_en !== 6'h3F) begin n_fail++; $display("FAIL grant_en: got %b want 111111", dig_en); end
        for (int k = 1; k < HOLD; k++) begin
            entry_clr = (k == 5);
            tick();
            entry_clr = 1'b0;
            n_checks++; if (busy !== 1'b1 || stat_ack !== 1'b0 || hex_out !== 24'hACCE55) begin
                n_fail++; $display("FAIL grant_hold[%0d]: got busy=%b ack=%b hex=%h want 1 0 acce55", k, busy, stat_ack, hex_out);
            end
        end
        tick();
        $display("granted end: busy=%b hex=%h en=%b", busy, hex_out, dig_en);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL grant_end_busy: got %b want 0", busy); end
        n_checks++; if (dig_en !== 6'h00 || hex_out !== 24'h0) begin n_fail++; $display("FAIL grant_end_disp: got %h/%b want 000000/000000", hex_out, dig_en); end
        entry_valid = 1'b1; entry_digit = 4'h7;
        tick();
        entry_valid = 1'b0;
        n_checks++; if (hex_out !== 24'h000007 || dig_en !== 6'h01) begin n_fail++; $display("FAIL post_grant_entry: got %h/%b want 000007/000001", hex_out, dig_en); end
    endtask

    task automatic test_denied();
        stat_req = 1'b1; stat_code = 2'd1;
        tick();
        stat_req = 1'b0;
        $display("denied: ack=%b busy=%b hex=%h en=%b", stat_ack, busy, hex_out, dig_en);
        n_checks++; if (stat_ack !== 1'b1) begin n_fail++; $display("FAIL deny_ack: got %b want 1", stat_ack); end
        n_checks++; if (hex_out !== 24'hDEAD00) begin n_fail++; $display("FAIL deny_hex: got %h want dead00", hex_out); end
        n_checks++; if (dig_en !== 6'b111100) begin n_fail++; $display("FAIL deny_en: got %b want 111100", dig_en); end
        for (int k = 1; k < HOLD; k++) begin
            if (k == 5) begin stat_req = 1'b1; stat_code = 2'd0; end
            entry_valid = (k == 7); entry_digit = 4'h3;
            tick();
            entry_valid = 1'b0;
            n_checks++; if (stat_ack !== 1'b0 || busy !== 1'b1 || hex_out !== 24'hDEAD00) begin
                n_fail++; $display("FAIL deny_hold[%0d]: got ack=%b busy=%b hex=%h want 0 1 dead00", k, stat_ack, busy, hex_out);
            end
        end
        tick();
        n_checks++; if (busy !== 1'b0 || stat_ack !== 1'b0) begin n_fail++; $display("FAIL deny_end: got busy=%b ack=%b want 0 0", busy, stat_ack); end
        tick();
        stat_req = 1'b0;
        $display("re-request: ack=%b busy=%b hex=%h", stat_ack, busy, hex_out);
        n_checks++; if (stat_ack !== 1'b1 || hex_out !== 24'hACCE55) begin n_fail++; $display("FAIL rereq_ack: got ack=%b hex=%h want 1 acce55", stat_ack, hex_out); end
        for (int k = 1; k <= HOLD; k++) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rereq_end: got busy=%b want 0", busy); end
        stat_req = 1'b1; stat_code = 2'd3;
        tick();
        stat_req = 1'b0;
        $display("code3: hex=%h en=%b", hex_out, dig_en);
        n_checks++; if (hex_out !== 24'hDEAD00 || dig_en !== 6'b111100) begin n_fail++; $display("FAIL code3: got %h/%b want dead00/111100", hex_out, dig_en); end
        for (int k = 1; k <= HOLD; k++) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL code3_end: got busy=%b want 0", busy); end
    endtask

    task automatic run_locked(input int cycles);
        logic [5:0] exp_en;
        stat_req = 1'b1; stat_code = 2'd2;
        tick();
        stat_req = 1'b0;
        $display("locked: ack=%b busy=%b hex=%h en=%b", stat_ack, busy, hex_out, dig_en);
        n_checks++; if (stat_ack !== 1'b1 || hex_out !== 24'hC105ED || dig_en !== 6'h3F) begin
            n_fail++; $display("FAIL lock_start: got ack=%b hex=%h en=%b want 1 c105ed 111111", stat_ack, hex_out, dig_en);
        end
        for (int m = 1; m < cycles; m++) begin
            tick();
            exp_en = ((m % (2 * BLINK)) < BLINK) ? 6'h3F : 6'h00;
            n_checks++; if (dig_en !== exp_en || busy !== 1'b1) begin
                n_fail++; $display("FAIL lock_blink[%0d]: got en=%b busy=%b want %b 1", m, dig_en, busy, exp_en);
            end
        end
    endtask

    task automatic test_locked();
        run_locked(28);
        entry_clr = 1'b1;
        tick();
        entry_clr = 1'b0;
        $display("locked clr: busy=%b en=%b hex=%h", busy, dig_en, hex_out);
        n_checks++; if (busy !== 1'b0 || dig_en !== 6'h00) begin n_fail++; $display("FAIL lock_clr: got busy=%b en=%b want 0 000000", busy, dig_en); end
        run_locked(6);
        entry_clr = 1'b1;
        tick();
        entry_clr = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lock_clr2: got busy=%b want 0", busy); end
    endtask

    task automatic test_async_reset();
        run_locked(6);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: hex=%h en=%b busy=%b ack=%b", hex_out, dig_en, busy, stat_ack);
        n_checks++; if (hex_out !== 24'h0 || dig_en !== 6'h00 || busy !== 1'b0 || stat_ack !== 1'b0) begin
            n_fail++; $display("FAIL async_rst: got hex=%h en=%b busy=%b ack=%b want all zero", hex_out, dig_en, busy, stat_ack);
        end
        tick();
        rst_n = 1'b1;
        entry_valid = 1'b1; entry_digit = 4'h4;
        tick();
        entry_valid = 1'b0;
        $display("after reset entry: hex=%h en=%b", hex_out, dig_en);
        n_checks++; if (hex_out !== 24'h000004 || dig_en !== 6'h01) begin n_fail++; $display("FAIL post_rst_entry: got %h/%b want 000004/000001", hex_out, dig_en); end
    endtask

    initial begin
        rst_n = 1'b0; entry_valid = 1'b0; entry_digit = 4'h0; entry_clr = 1'b0;
        stat_req = 1'b0; stat_code = 2'd0;
        test_reset();
        test_entry();
        test_granted();
        test_denied();
        test_locked();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
